// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer for the PC register and the instruction-memory
// fetch handshake. It merges load-use stalls, ID-stage redirects and a multi-cycle
// imem ack. It buffers one redirect while a fetch is outstanding, and it raises a
// sticky error when imem does not answer in time.
module fetch_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int COUNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [31:0]        pc_i,
    input  logic               load_use_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_target_i,
    input  logic               imem_ack_i,
    output logic [31:0]        next_pc_o,
    output logic               hazard_pc_o,
    output logic               imem_req_o,
    output logic               ifid_stall_o,
    output logic               ifid_flush_o,
    output logic               err_o,
    output logic [COUNT_W-1:0] fetch_cnt_o
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_cnt_next;
    logic                pend_valid;
    logic [31:0]         pend_target;
    logic [COUNT_W-1:0]  fetch_cnt;
    logic                advance;

    // The PC moves only when the fetch is acked and no load-use hazard holds it back.
    always_comb begin
        advance = (state == REQ) && imem_ack_i && !load_use_i;
    end

    // Next state and wait counter. A request is held until its ack arrives.
    // TIMEOUT consecutive unanswered REQ cycles lock the block in ERR.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next    = REQ;
                    wait_cnt_next = '0;
                end
            end
            REQ: begin
                if (imem_ack_i) begin
                    wait_cnt_next = '0;
                    if (!start_i) begin
                        state_next = IDLE;
                    end
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    state_next = ERR;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Pending redirect: holds a redirect that could not be applied yet.
    // A newer redirect replaces it. It is consumed on the next advance.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (redirect_i && !advance) begin
            pend_valid  <= 1'b1;
            pend_target <= redirect_target_i;
        end else if (advance) begin
            pend_valid  <= 1'b0;
        end
    end

    // Count PC advances. The counter wraps naturally at its width.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt <= '0;
        end else if (advance) begin
            fetch_cnt <= fetch_cnt + COUNT_W'(1);
        end
    end

    // PC selection, handshake and pipeline-register controls. A live redirect
    // outranks a pending one, which outranks sequential fetch.
    always_comb begin
        if (redirect_i) begin
            next_pc_o = redirect_target_i;
        end else if (pend_valid) begin
            next_pc_o = pend_target;
        end else begin
            next_pc_o = pc_i + 32'd4;
        end
        hazard_pc_o  = !advance;
        imem_req_o   = (state == REQ);
        ifid_flush_o = advance && (redirect_i || pend_valid);
        ifid_stall_o = !ifid_flush_o &&
                       (load_use_i || ((state == REQ) && !imem_ack_i));
        err_o        = (state == ERR);
        fetch_cnt_o  = fetch_cnt;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: drives fetch_ctrl one cycle at a time from a table of vectors,
// then runs hand-built timeout and counter-clear sequences. Expected values are
// queued when stimulus is applied and compared when the outputs settle.
module tb_fetch_ctrl;

    typedef struct {
        logic        rst;
        logic        start;
        logic        load_use;
        logic        redirect;
        logic [31:0] target;
        logic        ack;
        logic [31:0] pc;
        logic [31:0] exp_next;
        logic        exp_hazard;
        logic        exp_req;
        logic        exp_stall;
        logic        exp_flush;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        load_use_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic        imem_ack_i;
    logic [31:0] next_pc_o;
    logic        hazard_pc_o;
    logic        imem_req_o;
    logic        ifid_stall_o;
    logic        ifid_flush_o;
    logic        err_o;
    logic [15:0] fetch_cnt_o;

    int   checks   = 0;
    int   failures = 0;
    vec_t sb_q[$];
    vec_t table_q[$];

    fetch_ctrl #(.TIMEOUT(16), .COUNT_W(16)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .pc_i              (pc_i),
        .load_use_i        (load_use_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .imem_ack_i        (imem_ack_i),
        .next_pc_o         (next_pc_o),
        .hazard_pc_o       (hazard_pc_o),
        .imem_req_o        (imem_req_o),
        .ifid_stall_o      (ifid_stall_o),
        .ifid_flush_o      (ifid_flush_o),
        .err_o             (err_o),
        .fetch_cnt_o       (fetch_cnt_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic rst, logic start, logic lu, logic rd,
                                logic [31:0] tgt, logic ack, logic [31:0] pc,
                                logic [31:0] nxt, logic haz, logic req,
                                logic stall, logic flush, logic err,
                                logic [15:0] cnt);
        vec_t v;
        v.rst = rst;           v.start = start;       v.load_use = lu;
        v.redirect = rd;       v.target = tgt;        v.ack = ack;
        v.pc = pc;             v.exp_next = nxt;      v.exp_hazard = haz;
        v.exp_req = req;       v.exp_stall = stall;   v.exp_flush = flush;
        v.exp_err = err;       v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic checkField(input string name, input int row,
                              input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s row=%0d got=0x%08h required=0x%08h",
                     name, row, actual, expected);
        end
    endtask

    // Drive one cycle of inputs shortly after the rising edge and queue its expectation.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk_i);
        #1;
        rst_i             = v.rst;
        start_i           = v.start;
        load_use_i        = v.load_use;
        redirect_i        = v.redirect;
        redirect_target_i = v.target;
        imem_ack_i        = v.ack;
        pc_i              = v.pc;
        sb_q.push_back(v);
    endtask

    // Compare settled outputs on the falling edge against the oldest expectation.
    task automatic checkOutput(input int row);
        vec_t e;
        @(negedge clk_i);
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard row=%0d got=empty required=entry", row);
        end else begin
            checks--;
            e = sb_q.pop_front();
            checkField("next_pc",   row, next_pc_o,            e.exp_next);
            checkField("hazard_pc", row, {31'd0, hazard_pc_o}, {31'd0, e.exp_hazard});
            checkField("imem_req",  row, {31'd0, imem_req_o},  {31'd0, e.exp_req});
            checkField("ifid_stall",row, {31'd0, ifid_stall_o},{31'd0, e.exp_stall});
            checkField("ifid_flush",row, {31'd0, ifid_flush_o},{31'd0, e.exp_flush});
            checkField("err",       row, {31'd0, err_o},       {31'd0, e.exp_err});
            checkField("fetch_cnt", row, {16'd0, fetch_cnt_o}, {16'd0, e.exp_cnt});
        end
    endtask

    task automatic runVec(input vec_t v, input int row);
        applyStimulus(v);
        checkOutput(row);
    endtask

    initial begin
        vec_t v;
        int   row;

        rst_i = 1'b0; start_i = 1'b0; load_use_i = 1'b0; redirect_i = 1'b0;
        redirect_target_i = 32'd0; imem_ack_i = 1'b0; pc_i = 32'd0;

        // rst st lu rd target ack pc | next haz req stall flush err cnt
        table_q.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h4,  1,0,0,0,0,0));
        table_q.push_back(mk(1,1,0,0,32'h0,  0,32'h0,        32'h4,  1,0,0,0,0,0));
        table_q.push_back(mk(1,1,0,0,32'h0,  0,32'h0,        32'h4,  1,1,1,0,0,0));
        table_q.push_back(mk(1,1,0,0,32'h0,  1,32'h0,        32'h4,  0,1,0,0,0,0));
        table_q.push_back(mk(1,1,0,0,32'h0,  0,32'h4,        32'h8,  1,1,1,0,0,1));
        table_q.push_back(mk(1,1,0,1,32'h100,1,32'h4,        32'h100,0,1,0,1,0,1));
        table_q.push_back(mk(1,1,0,0,32'h0,  0,32'h100,      32'h104,1,1,1,0,0,2));
        table_q.push_back(mk(1,1,0,1,32'h200,0,32'h100,      32'h200,1,1,1,0,0,2));
        table_q.push_back(mk(1,1,0,1,32'h300,0,32'h100,      32'h300,1,1,1,0,0,2));
        table_q.push_back(mk(1,1,0,0,32'h0,  0,32'h100,      32'h300,1,1,1,0,0,2));
        table_q.push_back(mk(1,1,0,0,32'h0,  1,32'h100,      32'h300,0,1,0,1,0,2));
        table_q.push_back(mk(1,1,0,0,32'h0,  0,32'h300,      32'h304,1,1,1,0,0,3));
        table_q.push_back(mk(1,1,1,0,32'h0,  1,32'h300,      32'h304,1,1,1,0,0,3));
        table_q.push_back(mk(1,1,0,0,32'h0,  0,32'h300,      32'h304,1,1,1,0,0,3));
        table_q.push_back(mk(1,1,0,0,32'h0,  1,32'h300,      32'h304,0,1,0,0,0,3));
        table_q.push_back(mk(1,1,0,0,32'h0,  0,32'h304,      32'h308,1,1,1,0,0,4));
        table_q.push_back(mk(1,1,0,0,32'h0,  1,32'hFFFFFFFC, 32'h0,  0,1,0,0,0,4));
        table_q.push_back(mk(1,0,0,0,32'h0,  0,32'h0,        32'h4,  1,1,1,0,0,5));
        table_q.push_back(mk(1,0,0,0,32'h0,  1,32'h0,        32'h4,  0,1,0,0,0,5));
        table_q.push_back(mk(1,0,0,0,32'h0,  0,32'h4,        32'h8,  1,0,0,0,0,6));
        table_q.push_back(mk(1,0,0,1,32'h400,0,32'h4,        32'h400,1,0,0,0,0,6));
        table_q.push_back(mk(1,1,0,0,32'h0,  0,32'h4,        32'h400,1,0,0,0,0,6));
        table_q.push_back(mk(1,1,0,0,32'h0,  1,32'h4,        32'h400,0,1,0,1,0,6));
        table_q.push_back(mk(1,1,0,0,32'h0,  0,32'h400,      32'h404,1,1,1,0,0,7));
        table_q.push_back(mk(0,1,0,0,32'h0,  0,32'h400,      32'h404,1,0,0,0,0,0));
        table_q.push_back(mk(1,0,1,0,32'h0,  0,32'h400,      32'h404,1,0,1,0,0,0));

        $display("[TB] table vectors");
        for (int i = 0; i < table_q.size(); i++) begin
            runVec(table_q[i], i);
        end

        // Timeout: one IDLE cycle, 16 unanswered REQ cycles, then ERR, which holds even if an ack shows up.
        $display("[TB] timeout sequence");
        row = 100;
        runVec(mk(0,0,0,0,32'h0,0,32'h40,32'h44,1,0,0,0,0,0), row++);
        runVec(mk(1,1,0,0,32'h0,0,32'h40,32'h44,1,0,0,0,0,0), row++);
        for (int k = 0; k < 16; k++) begin
            runVec(mk(1,1,0,0,32'h0,0,32'h40,32'h44,1,1,1,0,0,0), row++);
        end
        runVec(mk(1,1,0,0,32'h0,0,32'h40,32'h44,1,0,0,0,1,0), row++);
        runVec(mk(1,1,0,0,32'h0,1,32'h40,32'h44,1,0,0,0,1,0), row++);
        runVec(mk(1,1,0,0,32'h0,1,32'h40,32'h44,1,0,0,0,1,0), row++);
        runVec(mk(0,1,0,0,32'h0,1,32'h40,32'h44,1,0,0,0,0,0), row++);
        runVec(mk(1,0,0,0,32'h0,0,32'h40,32'h44,1,0,0,0,0,0), row++);

        // An ack on the 16th REQ cycle clears the wait count, so a second run of 15 misses stays clean.
        $display("[TB] wait counter clear sequence");
        row = 200;
        runVec(mk(1,1,0,0,32'h0,0,32'h80,32'h84,1,0,0,0,0,0), row++);
        for (int k = 0; k < 15; k++) begin
            runVec(mk(1,1,0,0,32'h0,0,32'h80,32'h84,1,1,1,0,0,0), row++);
        end
        runVec(mk(1,1,0,0,32'h0,1,32'h80,32'h84,0,1,0,0,0,0), row++);
        for (int k = 0; k < 15; k++) begin
            runVec(mk(1,1,0,0,32'h0,0,32'h84,32'h88,1,1,1,0,0,1), row++);
        end
        runVec(mk(1,1,0,0,32'h0,1,32'h84,32'h88,0,1,0,0,0,1), row++);
        runVec(mk(1,1,0,0,32'h0,0,32'h88,32'h8C,1,1,1,0,0,2), row++);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
